spi_cmd_queue: RTL and testbench
================================

Name: spi_cmd_queue

Overview:
Command buffer and sequencer that sits directly upstream of the SPI transmitter used to program the RF front-end configuration registers. Software or control logic pushes (data, width) words into a small FIFO. The block drains them one at a time into the transmitter using its start/busy/done handshake, with a programmable inter-word gap and a done-timeout watchdog. Status counters and sticky error flags are exported for the register bank.

Parameters:
DEPTH, 8, FIFO entries; must be a power of two, minimum 2.
ADDR_W, 3, log2(DEPTH).

Ports:
clk  in  1  clock
nrst  in  1  synchronous active-low reset
wr_en  in  1  push request, one word per cycle
wr_data  in  32  word to transmit, right-aligned
wr_width  in  5  transmit width minus 1 (0..31 means 1..32 bits)
flush  in  1  discard all queued (not in-flight) entries
enable  in  1  permit issuing new transfers
gap_cycles  in  16  idle clocks enforced between consecutive transfers
timeout  in  24  max clocks to wait for tx_done; 0 disables the watchdog
clr_err  in  1  clears overflow and timeout_err
tx_start  out  1  start pulse to the transmitter (registered)
tx_data  out  32  data to the transmitter (registered, held)
tx_width  out  5  width to the transmitter (registered, held)
tx_busy  in  1  transmitter busy
tx_done  in  1  transmitter done, one-cycle pulse
full  out  1  FIFO full
empty  out  1  FIFO empty
level  out  ADDR_W+1  entries queued
sent_count  out  16  completed transfers, wraps at 16 bits
overflow  out  1  sticky: a push was dropped
timeout_err  out  1  sticky: the watchdog fired
idle  out  1  state==IDLE and empty

Behaviour:
- Reset values (synchronous reset on nrst low): FIFO empty, pointers 0, level 0, state IDLE, tx_start 0, tx_data 0, tx_width 0, sent_count 0, overflow 0, timeout_err 0, gap and watchdog counters 0. Reset mid-transfer abandons everything; the transmitter gets its own reset.
- FIFO: circular, DEPTH entries of 37 bits; full/empty/level are registered.
- Push when full: the word is dropped and overflow is set, even if a pop happens in the same cycle.
- Push and pop in the same cycle on a non-full FIFO: level is unchanged.
- flush empties the FIFO next cycle and overrides a same-cycle push (the push is dropped, overflow not set).
- flush does not affect a transfer already in flight.
- clr_err clears both sticky flags; a same-cycle error event wins over clr_err.
- FSM IDLE -> ISSUE -> WAIT_DONE -> GAP -> IDLE.
- IDLE: when enable && !empty && !tx_busy:
  - load tx_data/tx_width from the FIFO head, assert tx_start, pop the entry, go to ISSUE.
- ISSUE: lasts exactly 1 cycle with tx_start=1; tx_start drops next cycle; go to WAIT_DONE.
- tx_data and tx_width hold their values until the next issue.
- WAIT_DONE:
  - on tx_done: sent_count+1, then go to GAP if gap_cycles!=0, else IDLE.
  - watchdog counts cycles spent in WAIT_DONE. If timeout!=0 and the count reaches timeout, set timeout_err, do not increment sent_count, and go to GAP/IDLE by the same rule as tx_done.
  - tx_done in the same cycle as the timeout: counts as success; timeout_err is not set.
- GAP: stays exactly gap_cycles cycles, then IDLE.
- Latency: a word pushed at edge N into an empty idle queue gives tx_start=1 during cycle N+1..N+2. This is the earliest possible start.
- Back-to-back throughput: the next tx_start rises gap_cycles+1 cycles after the tx_done cycle.
- enable low: the in-flight transfer completes normally; no new issue happens until enable is high.
- tx_done outside WAIT_DONE is ignored.
- sent_count wraps from 0xFFFF to 0.

Test Plan:
- Single word: push 0xA5 width 7, enable=1, gap=0 -> tx_start high 1 cycle at N+1, tx_data=0xA5, tx_width=7; after the model's tx_done, sent_count=1, idle=1.
- Back-to-back: push 3 words, gap=4 -> three starts, in order; each start is 5 cycles after the previous tx_done; sent_count=3, level back to 0.
- Overflow and flush: push 9 words with enable=0 (DEPTH=8) -> full=1, level=8, overflow=1. flush -> level=0, empty=1. clr_err -> overflow=0.
- Timeout: timeout=20, model never asserts done -> timeout_err=1 after 20 WAIT_DONE cycles, sent_count unchanged, next queued word still issued.
- Done/timeout collision: tx_done arrives in exactly the timeout cycle -> sent_count+1, timeout_err=0.
- Reset mid-WAIT_DONE with 2 entries queued -> next cycle: state IDLE, level=0, tx_start=0, counters and flags 0.

Source files
------------

// File: rtl/spi_cmd_queue.sv
// spi_cmd_queue: command FIFO and sequencer in front of the RF-config SPI
// transmitter. Words are queued as {width, data}. They are issued one at a
// time over the start/busy/done handshake. The block enforces a programmable
// idle gap between transfers and runs a watchdog on tx_done. Status and sticky
// error flags are exported for the register bank.
module spi_cmd_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              wr_en,
    input  logic [31:0]       wr_data,
    input  logic [4:0]        wr_width,
    input  logic              flush,
    input  logic              enable,
    input  logic [15:0]       gap_cycles,
    input  logic [23:0]       timeout,
    input  logic              clr_err,
    output logic              tx_start,
    output logic [31:0]       tx_data,
    output logic [4:0]        tx_width,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic [15:0]       sent_count,
    output logic              overflow,
    output logic              timeout_err,
    output logic              idle
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_GAP       = 2'd3;

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);

    // Queue storage: {width[4:0], data[31:0]} per entry
    logic [36:0] mem [DEPTH];
    logic [36:0] head;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;

    logic [1:0]        state_q, state_d;
    logic              tx_start_q, tx_start_d;
    logic [31:0]       tx_data_q, tx_data_d;
    logic [4:0]        tx_width_q, tx_width_d;
    logic [15:0]       sent_q, sent_d;
    logic [15:0]       gap_cnt_q, gap_cnt_d;
    logic [23:0]       wdog_q, wdog_d;
    logic              ovf_q, ovf_d;
    logic              terr_q, terr_d;

    logic issue;
    logic push_ok;
    logic push_drop;
    logic xfer_ok;
    logic wdog_fire;
    logic xfer_end;

    // Flush pre-empts both the push and any issue in the same cycle, so that
    // every entry still queued is discarded.
    assign issue     = (state_q == S_IDLE) && enable && !empty_q && !tx_busy && !flush;
    assign push_ok   = wr_en && !flush && !full_q;
    assign push_drop = wr_en && !flush && full_q;
    assign xfer_ok   = (state_q == S_WAIT_DONE) && tx_done;
    // A done in the same cycle as the watchdog expiry is counted as success.
    assign wdog_fire = (state_q == S_WAIT_DONE) && !tx_done && (timeout != 24'd0)
                       && ((wdog_q + 24'd1) == timeout);
    assign xfer_end  = xfer_ok || wdog_fire;

    assign head = mem[rd_ptr_q];

    // Storage write port: only accepted pushes land in the array
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= {wr_width, wr_data};
        end
    end

    // FIFO pointer and occupancy update, with flags derived from the next level
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (issue) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push_ok && !issue) begin
                level_d = level_q + LVL_ONE;
            end else if (!push_ok && issue) begin
                level_d = level_q - LVL_ONE;
            end
        end
        full_d  = (level_d == LVL_FULL);
        empty_d = (level_d == '0);
    end

    // Sequencer: issue, wait for done or watchdog, then hold off for the gap
    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        tx_width_d = tx_width_q;
        sent_d     = sent_q;
        gap_cnt_d  = gap_cnt_q;
        wdog_d     = wdog_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = head[31:0];
                    tx_width_d = head[36:32];
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                wdog_d = wdog_q + 24'd1;
                if (xfer_ok) begin
                    sent_d = sent_q + 16'd1;
                end
                if (xfer_end) begin
                    wdog_d    = '0;
                    gap_cnt_d = '0;
                    state_d   = (gap_cycles != 16'd0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                // Use >= so a gap shortened mid-count still terminates
                gap_cnt_d = gap_cnt_q + 16'd1;
                if ((gap_cnt_q + 16'd1) >= gap_cycles) begin
                    gap_cnt_d = '0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sticky error flags: a same-cycle error event wins over clr_err
    always_comb begin
        ovf_d  = ovf_q;
        terr_d = terr_q;
        if (clr_err) begin
            ovf_d  = 1'b0;
            terr_d = 1'b0;
        end
        if (push_drop) begin
            ovf_d = 1'b1;
        end
        if (wdog_fire) begin
            terr_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            state_q    <= S_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            tx_width_q <= '0;
            sent_q     <= '0;
            gap_cnt_q  <= '0;
            wdog_q     <= '0;
            ovf_q      <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            tx_width_q <= tx_width_d;
            sent_q     <= sent_d;
            gap_cnt_q  <= gap_cnt_d;
            wdog_q     <= wdog_d;
            ovf_q      <= ovf_d;
            terr_q     <= terr_d;
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign tx_width    = tx_width_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign level       = level_q;
    assign sent_count  = sent_q;
    assign overflow    = ovf_q;
    assign timeout_err = terr_q;
    assign idle        = (state_q == S_IDLE) && empty_q;

endmodule

// File: tb/tb_spi_cmd_queue.sv
// tb_spi_cmd_queue: randomized scenarios against a queue-based reference of
// the command buffer, with the bench acting as the SPI transmitter.
module tb_spi_cmd_queue;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              nrst;
    logic              wr_en;
    logic [31:0]       wr_data;
    logic [4:0]        wr_width;
    logic              flush;
    logic              enable;
    logic [15:0]       gap_cycles;
    logic [23:0]       timeout;
    logic              clr_err;
    logic              tx_start;
    logic [31:0]       tx_data;
    logic [4:0]        tx_width;
    logic              tx_busy;
    logic              tx_done;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic [15:0]       sent_count;
    logic              overflow;
    logic              timeout_err;
    logic              idle;

    spi_cmd_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .nrst(nrst), .wr_en(wr_en), .wr_data(wr_data), .wr_width(wr_width),
        .flush(flush), .enable(enable), .gap_cycles(gap_cycles), .timeout(timeout),
        .clr_err(clr_err), .tx_start(tx_start), .tx_data(tx_data), .tx_width(tx_width),
        .tx_busy(tx_busy), .tx_done(tx_done), .full(full), .empty(empty), .level(level),
        .sent_count(sent_count), .overflow(overflow), .timeout_err(timeout_err), .idle(idle)
    );

    always #5 clk = ~clk;

    // Count of rising edges; read at negedges it names the edge just taken
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: expected queue contents, completed count and sticky flags
    logic [36:0] model_q [$];
    int          model_sent;
    logic        model_ovf;
    logic        model_terr;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_clear();
        model_q.delete();
        model_sent = 0;
        model_ovf  = 1'b0;
        model_terr = 1'b0;
    endtask

    task automatic model_push(input logic [31:0] d, input logic [4:0] w);
        if (model_q.size() >= DEPTH) model_ovf = 1'b1;
        else model_q.push_back({w, d});
    endtask

    task automatic pop_model(output logic [36:0] w);
        if (model_q.size() > 0) w = model_q.pop_front();
        else w = 'x;
    endtask

    task automatic push_word(input logic [31:0] d, input logic [4:0] w);
        wr_en    = 1'b1;
        wr_data  = d;
        wr_width = w;
        model_push(d, w);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_start(output int edge_idx);
        edge_idx = -1;
        for (int i = 0; i < 400; i++) begin
            if (tx_start === 1'b1) begin
                edge_idx = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Transmitter stand-in: busy after start, done pulse after lat cycles
    task automatic serve(input int lat, output int done_edge, output logic pulse);
        tx_busy = 1'b1;
        @(negedge clk);
        pulse = tx_start;
        repeat (lat) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        done_edge = cyc;
        tx_done = 1'b0;
        tx_busy = 1'b0;
        model_sent++;
    endtask

    task automatic show_xfer();
        $display("[%0d] xfer data=%08h width=%0d sent=%0d", cyc, tx_data, tx_width, sent_count);
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        model_clear();
        n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        n_cmp++; if (tx_data !== 32'd0) begin n_bad++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
        n_cmp++; if (tx_width !== 5'd0) begin n_bad++; $display("FAIL reset_tx_width: got %0d want 0", tx_width); end
        n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
        n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL reset_flags: empty=%b full=%b want 1/0", empty, full); end
        n_cmp++; if (sent_count !== 16'd0) begin n_bad++; $display("FAIL reset_sent: got %0d want 0", sent_count); end
        n_cmp++; if (overflow !== 1'b0 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: ovf=%b terr=%b want 0/0", overflow, timeout_err); end
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %b want 1", idle); end
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int p, s, d;
        logic pulse;
        logic [36:0] e;
        enable = 1'b1; gap_cycles = 16'd0; timeout = 24'd0;
        push_word(32'h0000_00A5, 5'd7);
        p = cyc;
        n_cmp++; if (tx_start !== 1'b0 || level !== 4'd1) begin n_bad++; $display("FAIL single_queued: tx_start=%b level=%0d want 0/1", tx_start, level); end
        wait_start(s);
        n_cmp++; if (s < 0) begin n_bad++; $display("FAIL single_start: no tx_start seen, want one"); return; end
        n_cmp++; if (s != p + 1) begin n_bad++; $display("FAIL single_latency: start edge %0d want %0d", s, p + 1); end
        pop_model(e);
        n_cmp++; if ({tx_width, tx_data} !== e) begin n_bad++; $display("FAIL single_word: got %0d/%h want %0d/%h", tx_width, tx_data, e[36:32], e[31:0]); end
        show_xfer();
        serve(3, d, pulse);
        n_cmp++; if (pulse !== 1'b0) begin n_bad++; $display("FAIL single_pulse: tx_start=%b one cycle later want 0", pulse); end
        n_cmp++; if (sent_count !== 16'(model_sent)) begin n_bad++; $display("FAIL single_sent: got %0d want %0d", sent_count, model_sent); end
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL single_idle: got %b want 1", idle); end
    endtask

    task automatic test_back_to_back();
        int s, d, prev_d;
        logic pulse;
        logic [36:0] e;
        enable = 1'b0; gap_cycles = 16'd4; timeout = 24'd0;
        prev_d = 0;
        for (int i = 0; i < 3; i++) push_word($urandom, 5'($urandom_range(0, 31)));
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_start(s);
            n_cmp++; if (s < 0) begin n_bad++; $display("FAIL b2b_start%0d: no tx_start seen, want one", i); return; end
            pop_model(e);
            n_cmp++; if ({tx_width, tx_data} !== e) begin n_bad++; $display("FAIL b2b_word%0d: got %0d/%h want %0d/%h", i, tx_width, tx_data, e[36:32], e[31:0]); end
            if (i > 0) begin
                n_cmp++; if (s - prev_d != 5) begin n_bad++; $display("FAIL b2b_spacing%0d: %0d cycles after done want 5", i, s - prev_d); end
            end
            show_xfer();
            serve($urandom_range(0, 5), d, pulse);
            n_cmp++; if (pulse !== 1'b0) begin n_bad++; $display("FAIL b2b_pulse%0d: tx_start=%b want 0", i, pulse); end
            prev_d = d;
        end
        n_cmp++; if (sent_count !== 16'(model_sent)) begin n_bad++; $display("FAIL b2b_sent: got %0d want %0d", sent_count, model_sent); end
        n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL b2b_level: got %0d want 0", level); end
        repeat (5) @(negedge clk);
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL b2b_idle: got %b want 1", idle); end
    endtask

    task automatic test_random_stream();
        int s, d, prev_d, g, n, exp_edge;
        logic pulse;
        logic [36:0] e;
        timeout = 24'd0;
        for (int r = 0; r < 4; r++) begin
            g = $urandom_range(0, 5);
            n = $urandom_range(1, 5);
            enable = 1'b0; gap_cycles = 16'(g);
            for (int i = 0; i < n; i++) push_word($urandom, 5'($urandom_range(0, 31)));
            n_cmp++; if (level !== 4'(model_q.size())) begin n_bad++; $display("FAIL rnd%0d_level: got %0d want %0d", r, level, model_q.size()); end
            enable = 1'b1;
            prev_d = 0;
            for (int i = 0; i < n; i++) begin
                exp_edge = (i == 0) ? cyc + 1 : prev_d + g + 1;
                wait_start(s);
                n_cmp++; if (s < 0) begin n_bad++; $display("FAIL rnd%0d_start%0d: no tx_start seen, want one", r, i); return; end
                n_cmp++; if (s != exp_edge) begin n_bad++; $display("FAIL rnd%0d_timing%0d: start edge %0d want %0d", r, i, s, exp_edge); end
                pop_model(e);
                n_cmp++; if ({tx_width, tx_data} !== e) begin n_bad++; $display("FAIL rnd%0d_word%0d: got %0d/%h want %0d/%h", r, i, tx_width, tx_data, e[36:32], e[31:0]); end
                show_xfer();
                serve($urandom_range(0, 7), d, pulse);
                prev_d = d;
            end
            n_cmp++; if (sent_count !== 16'(model_sent)) begin n_bad++; $display("FAIL rnd%0d_sent: got %0d want %0d", r, sent_count, model_sent); end
            repeat (g + 2) @(negedge clk);
        end
        enable = 1'b0;
    endtask

    task automatic test_overflow_flush();
        int d;
        logic pulse;
        logic [36:0] e;
        enable = 1'b0; gap_cycles = 16'd0; timeout = 24'd0;
        for (int i = 0; i < 9; i++) push_word($urandom, 5'($urandom_range(0, 31)));
        n_cmp++; if (full !== 1'b1 || empty !== 1'b0) begin n_bad++; $display("FAIL ovf_flags: full=%b empty=%b want 1/0", full, empty); end
        n_cmp++; if (level !== 4'(model_q.size())) begin n_bad++; $display("FAIL ovf_level: got %0d want %0d", level, model_q.size()); end
        n_cmp++; if (overflow !== model_ovf) begin n_bad++; $display("FAIL ovf_set: got %b want %b", overflow, model_ovf); end
        // flush beats a same-cycle push; the dropped push is not an overflow
        wr_en = 1'b1; wr_data = $urandom; flush = 1'b1;
        model_q.delete();
        @(negedge clk);
        wr_en = 1'b0; flush = 1'b0;
        n_cmp++; if (level !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL flush_state: level=%0d empty=%b full=%b want 0/1/0", level, empty, full); end
        n_cmp++; if (overflow !== model_ovf) begin n_bad++; $display("FAIL flush_ovf: got %b want %b", overflow, model_ovf); end
        clr_err = 1'b1; model_ovf = 1'b0;
        @(negedge clk);
        clr_err = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL clr_ovf: got %b want 0", overflow); end
        // Refill, then push while full with a same-cycle pop and clr_err
        for (int i = 0; i < 8; i++) push_word($urandom, 5'($urandom_range(0, 31)));
        wr_en = 1'b1; wr_data = $urandom; wr_width = 5'd3; clr_err = 1'b1; enable = 1'b1;
        model_ovf = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; clr_err = 1'b0; enable = 1'b0;
        n_cmp++; if (tx_start !== 1'b1) begin n_bad++; $display("FAIL pop_full_start: got %b want 1", tx_start); end
        pop_model(e);
        n_cmp++; if ({tx_width, tx_data} !== e) begin n_bad++; $display("FAIL pop_full_word: got %0d/%h want %0d/%h", tx_width, tx_data, e[36:32], e[31:0]); end
        n_cmp++; if (overflow !== model_ovf || level !== 4'(model_q.size())) begin n_bad++; $display("FAIL pop_full_ovf: ovf=%b level=%0d want %b/%0d", overflow, level, model_ovf, model_q.size()); end
        show_xfer();
        serve(1, d, pulse);
        flush = 1'b1; model_q.delete();
        @(negedge clk);
        flush = 1'b0; clr_err = 1'b1; model_ovf = 1'b0;
        @(negedge clk);
        clr_err = 1'b0;
        n_cmp++; if (level !== 4'd0 || overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_cleanup: level=%0d ovf=%b want 0/0", level, overflow); end
        n_cmp++; if (sent_count !== 16'(model_sent)) begin n_bad++; $display("FAIL ovf_sent: got %0d want %0d", sent_count, model_sent); end
    endtask

    task automatic test_timeout();
        int s, s2, d;
        logic pulse;
        logic [36:0] e;
        enable = 1'b0; gap_cycles = 16'd0; timeout = 24'd20;
        push_word($urandom, 5'($urandom_range(0, 31)));
        push_word($urandom, 5'($urandom_range(0, 31)));
        enable = 1'b1;
        wait_start(s);
        n_cmp++; if (s < 0) begin n_bad++; $display("FAIL tmo_start: no tx_start seen, want one"); return; end
        pop_model(e);
        n_cmp++; if ({tx_width, tx_data} !== e) begin n_bad++; $display("FAIL tmo_word: got %0d/%h want %0d/%h", tx_width, tx_data, e[36:32], e[31:0]); end
        show_xfer();
        tx_busy = 1'b1;
        while (cyc < s + 20) @(negedge clk);
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL tmo_early: got %b after 19 wait cycles want 0", timeout_err); end
        @(negedge clk);
        model_terr = 1'b1;
        n_cmp++; if (timeout_err !== model_terr) begin n_bad++; $display("FAIL tmo_fire: got %b after 20 wait cycles want 1", timeout_err); end
        n_cmp++; if (sent_count !== 16'(model_sent)) begin n_bad++; $display("FAIL tmo_sent: got %0d want %0d", sent_count, model_sent); end
        tx_busy = 1'b0;
        wait_start(s2);
        n_cmp++; if (s2 != s + 22) begin n_bad++; $display("FAIL tmo_next_start: edge %0d want %0d", s2, s + 22); end
        pop_model(e);
        n_cmp++; if ({tx_width, tx_data} !== e) begin n_bad++; $display("FAIL tmo_next_word: got %0d/%h want %0d/%h", tx_width, tx_data, e[36:32], e[31:0]); end
        show_xfer();
        serve(2, d, pulse);
        n_cmp++; if (sent_count !== 16'(model_sent) || timeout_err !== 1'b1) begin n_bad++; $display("FAIL tmo_after: sent=%0d terr=%b want %0d/1", sent_count, timeout_err, model_sent); end
        clr_err = 1'b1; model_terr = 1'b0;
        @(negedge clk);
        clr_err = 1'b0;
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL tmo_clear: got %b want 0", timeout_err); end
    endtask

    task automatic test_collision();
        int s;
        logic [36:0] e;
        enable = 1'b0; gap_cycles = 16'd0; timeout = 24'd20;
        push_word($urandom, 5'($urandom_range(0, 31)));
        enable = 1'b1;
        wait_start(s);
        n_cmp++; if (s < 0) begin n_bad++; $display("FAIL coll_start: no tx_start seen, want one"); return; end
        pop_model(e);
        n_cmp++; if ({tx_width, tx_data} !== e) begin n_bad++; $display("FAIL coll_word: got %0d/%h want %0d/%h", tx_width, tx_data, e[36:32], e[31:0]); end
        show_xfer();
        tx_busy = 1'b1;
        while (cyc < s + 20) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0; tx_busy = 1'b0;
        model_sent++;
        n_cmp++; if (sent_count !== 16'(model_sent)) begin n_bad++; $display("FAIL coll_sent: got %0d want %0d", sent_count, model_sent); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL coll_terr: got %b want 0", timeout_err); end
        // A stray done while idle must not count
        repeat (2) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
        n_cmp++; if (sent_count !== 16'(model_sent) || idle !== 1'b1) begin n_bad++; $display("FAIL stray_done: sent=%0d idle=%b want %0d/1", sent_count, idle, model_sent); end
    endtask

    task automatic test_reset_mid();
        int s, starts;
        logic [36:0] e;
        enable = 1'b0; gap_cycles = 16'd0; timeout = 24'd0;
        for (int i = 0; i < 3; i++) push_word($urandom, 5'($urandom_range(1, 31)));
        enable = 1'b1;
        wait_start(s);
        n_cmp++; if (s < 0) begin n_bad++; $display("FAIL rmid_start: no tx_start seen, want one"); return; end
        pop_model(e);
        show_xfer();
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (level !== 4'(model_q.size())) begin n_bad++; $display("FAIL rmid_level_before: got %0d want %0d", level, model_q.size()); end
        nrst = 1'b0;
        @(negedge clk);
        model_clear();
        n_cmp++; if (tx_start !== 1'b0 || tx_data !== 32'd0 || tx_width !== 5'd0) begin n_bad++; $display("FAIL rmid_tx: start=%b data=%h width=%0d want 0/0/0", tx_start, tx_data, tx_width); end
        n_cmp++; if (level !== 4'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL rmid_fifo: level=%0d empty=%b want 0/1", level, empty); end
        n_cmp++; if (sent_count !== 16'(model_sent) || overflow !== 1'b0 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL rmid_status: sent=%0d ovf=%b terr=%b want 0/0/0", sent_count, overflow, timeout_err); end
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL rmid_idle: got %b want 1", idle); end
        nrst = 1'b1; tx_busy = 1'b0;
        starts = 0;
        repeat (6) begin
            @(negedge clk);
            if (tx_start === 1'b1) starts++;
        end
        n_cmp++; if (starts != 0) begin n_bad++; $display("FAIL rmid_no_issue: %0d starts after reset want 0", starts); end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "bench timed out");
    end

    initial begin
        nrst = 1'b0; wr_en = 1'b0; wr_data = '0; wr_width = '0; flush = 1'b0;
        enable = 1'b0; gap_cycles = '0; timeout = '0; clr_err = 1'b0;
        tx_busy = 1'b0; tx_done = 1'b0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_random_stream();
        test_overflow_flush();
        test_timeout();
        test_collision();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
